aes_key_sched: RTL

- Iterative AES-128 key expansion stage. Sits between the round controller and the AES datapath.
- Consumes the controller's round number and advance strobe. Produces the round key that the AddRoundKey step uses for the current round.
- Generates one round key per advance cycle, in lock-step with the round counter, so the datapath never stalls on key availability.

---
 rtl/aes_key_sched.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/aes_key_sched.sv
// aes_key_sched: iterative AES-128 key expansion, one round key per advance strobe.
// round_key is the round-0 key bypass (key_in) while rndNo==0, otherwise the
// registered expanded key. rcon exposes the constant for the next step.
// Optional feature macro: AES_KS_KEY_CACHE_EN adds an 11-entry round-key cache
// with a one-cycle registered read port; without it rk_rd_data is tied to zero.
module aes_key_sched #(
   parameter int NR = 10
) (
   input  logic         clk,
   input  logic         rstn,
   input  logic         start,
   input  logic [3:0]   rndNo,
   input  logic [127:0] key_in,
   output logic [127:0] round_key,
   output logic [7:0]   rcon,
   output logic         key_rdy,
   input  logic [3:0]   rk_rd_idx,
   output logic [127:0] rk_rd_data
);

   // AES-128 has exactly ten rounds; refuse to build anything else.
   if (NR != 10) begin : g_bad_nr
      $error("aes_key_sched: NR must be 10 for AES-128");
   end

   localparam logic [3:0] LAST_RND = 4'(NR);

   // FIPS-197 forward S-box, entry 0 in the leftmost byte.
   localparam logic [0:255][7:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   function automatic logic [31:0] sub_word(input logic [31:0] w);
      return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] rc);
      return {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
   endfunction

   // One key expansion step: word 0 takes the rotated, substituted last word
   // plus the round constant, and each later word chains off its predecessor.
   function automatic logic [127:0] expand(input logic [127:0] k, input logic [7:0] rc);
      logic [31:0] t, w0, w1, w2, w3;
      t  = sub_word({k[23:0], k[31:24]}) ^ {rc, 24'h0};
      w0 = k[127:96] ^ t;
      w1 = k[95:64]  ^ w0;
      w2 = k[63:32]  ^ w1;
      w3 = k[31:0]   ^ w2;
      return {w0, w1, w2, w3};
   endfunction

   logic [127:0] rk_reg;
   logic [127:0] exp_src;
   logic [7:0]   exp_rc;
   logic [127:0] next_key;
   logic         rnd_first;
   logic         rnd_mid;

   assign rnd_first = (rndNo == 4'd0);
   assign rnd_mid   = (rndNo != 4'd0) && (rndNo < LAST_RND);

   // A single expansion datapath serves both the cipher-key load and later rounds.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
      exp_src = rk_reg;
      exp_rc  = rcon;
      if (rnd_first) begin
         exp_src = key_in;
         exp_rc  = 8'h01;
      end
      next_key = expand(exp_src, exp_rc);
   end

   // Round-0 key is bypassed straight from key_in; later rounds use the register.
   always_comb begin
      round_key = rk_reg;
      if (rnd_first) round_key = key_in;
   end

   // Expansion state advances only on the strobe; reset wins over start.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments; reset is synchronous, active-low.
      if (!rstn) begin
         rk_reg  <= '0;
         rcon    <= 8'h01;
         key_rdy <= 1'b0;
      end else if (start) begin
         if (rnd_first) begin
            rk_reg  <= next_key;
            rcon    <= 8'h02;
            key_rdy <= 1'b1;
         end else if (rnd_mid) begin
            rk_reg  <= next_key;
            rcon    <= xtime(rcon);
         end else if (rndNo == LAST_RND) begin
            rcon    <= 8'h01;
            key_rdy <= 1'b0;
         end
      end
   end

`ifdef AES_KS_KEY_CACHE_EN
   logic [127:0] cache_mem [0:NR];
   logic [NR:0]  cache_vld;
   logic [127:0] rd_data_q;
   logic         rd_idx_ok;

   assign rd_idx_ok  = (rk_rd_idx <= LAST_RND);
   assign rk_rd_data = rd_data_q;

   // Cache storage captures the cipher key and each newly expanded round key.
   always_ff @(posedge clk) begin
      // NOTE: storage has no reset; the valid bits alone decide what reads return.
      if (start && rnd_first) begin
         cache_mem[0] <= key_in;
      end
      if (start && (rnd_first || rnd_mid)) begin
         cache_mem[rndNo + 4'd1] <= next_key;
      end
   end

   // Valid bits restart at each new block so stale keys are never returned.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         cache_vld <= '0;
      end else if (start && rnd_first) begin
         cache_vld <= {{(NR - 1){1'b0}}, 2'b11};
      end else if (start && rnd_mid) begin
         cache_vld[rndNo + 4'd1] <= 1'b1;
      end
   end

   // Registered read port: zero for invalid entries or out-of-range indices.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         rd_data_q <= '0;
      end else if (rd_idx_ok && cache_vld[rk_rd_idx]) begin
         rd_data_q <= cache_mem[rk_rd_idx];
      end else begin
         rd_data_q <= '0;
      end
   end
`else
   logic unused_rd_idx;

   assign unused_rd_idx = ^rk_rd_idx;
   assign rk_rd_data    = '0;
`endif

endmodule
